crc_frame_ctrl: RTL

CRC_FRAME_CTRL -- requirements
Module: crc_frame_ctrl

---
 rtl/crc_frame_ctrl.sv | 136 +++++++++++++
 1 files changed

// File: rtl/crc_frame_ctrl.sv
// Frame sequencer for an external 64-bit-parallel CRC-5 engine.
// Clears the engine, streams len words into it, then captures and compares the result.
module crc_frame_ctrl #(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [4:0]       exp_crc,
  input  logic             abort,
  input  logic             s_valid,
  input  logic [63:0]      s_data,
  output logic             s_ready,
  output logic [63:0]      crc_data,
  output logic             crc_en,
  output logic             crc_clr_n,
  input  logic [4:0]       crc_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             err_len,
  output logic [4:0]       crc_result
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    FEED   = 3'd2,
    SETTLE = 3'd3,
    CHECK  = 3'd4
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W-1:0] r_cnt;
  logic [4:0]       r_exp_crc;
  logic [4:0]       r_crc_result;
  logic             r_pass;
  logic             r_err_len;

  logic             w_ready;
  logic             w_accept;
  logic             w_last;
  logic             w_start_ok;
  logic             w_start_bad;
  logic             w_capture;

  assign w_start_ok  = (r_state == IDLE) && start && (len != '0);
  assign w_start_bad = (r_state == IDLE) && start && (len == '0);
  assign w_accept    = s_valid && w_ready;
  assign w_last      = w_accept && (r_cnt == (r_len - LEN_W'(1)));
  // The engine samples crc_in's update one cycle after the last word, so SETTLE is the capture point.
  assign w_capture   = (r_state == SETTLE) && !abort;

  always_comb begin
    w_next  = r_state;
    w_ready = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_start_ok) w_next = CLEAR;
      end
      CLEAR: begin
        w_next = FEED;
      end
      FEED: begin
        w_ready = 1'b1;
        if (w_last) w_next = SETTLE;
      end
      SETTLE: begin
        w_next = CHECK;
      end
      CHECK: begin
        w_next = IDLE;
      end
      default: begin
        w_next = IDLE;
      end
    endcase
    // Abort wins over everything, including a same-cycle final accept.
    if (abort && (r_state != IDLE)) w_next = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_len     <= '0;
      r_exp_crc <= '0;
      r_cnt     <= '0;
    end else if (w_start_ok) begin
      r_len     <= len;
      r_exp_crc <= exp_crc;
      r_cnt     <= '0;
    end else if (w_accept) begin
      r_cnt     <= r_cnt + LEN_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_crc_result <= 5'h00;
      r_pass       <= 1'b0;
    end else if (w_capture) begin
      r_crc_result <= crc_in;
      r_pass       <= (crc_in == r_exp_crc);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_len <= 1'b0;
    end else begin
      r_err_len <= w_start_bad;
    end
  end

  assign s_ready    = w_ready;
  assign crc_en     = w_accept;
  assign crc_data   = s_data;
  // Held low during reset so the engine is seeded from the moment reset asserts.
  assign crc_clr_n  = rst && (r_state != CLEAR);
  assign busy       = (r_state != IDLE);
  assign done       = (r_state == CHECK) && !abort;
  assign pass       = r_pass;
  assign err_len    = r_err_len;
  assign crc_result = r_crc_result;

endmodule
